// File: rtl/softmax_normalizer.sv
// Softmax normalisation stage: buffers one vector of e^x values, sums them, then
// streams each buffered value divided by the sum.
module softmax_normalizer #(
    parameter int N    = 8,
    parameter int IDXW = $clog2(N) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy
);

    localparam int AW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {LOAD, DRAIN} state_t;

    state_t            state, state_next;
    logic [31:0]       mem [N];
    logic [IDXW-1:0]   wr_idx, rd_idx, len;
    logic [31:0]       acc;
    logic              started;
    logic              in_end;

    // Float sum for non-negative operands, round to nearest even, denormals flushed.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [7:0]  d;
        logic [26:0] mx, my, sh;
        logic        sticky, up;
        logic [27:0] s;
        logic [8:0]  e;
        logic [24:0] m;
        if (a[30:23] >= b[30:23]) begin
            x = a; y = b;
        end else begin
            x = b; y = a;
        end
        if (y[30:23] == 8'd0) return x;
        d  = x[30:23] - y[30:23];
        mx = {1'b1, x[22:0], 3'b000};
        my = {1'b1, y[22:0], 3'b000};
        if (d >= 8'd27) begin
            sh     = '0;
            sticky = 1'b1;
        end else begin
            sh     = my >> d;
            sticky = ((sh << d) != my);
        end
        s = {1'b0, mx} + {1'b0, sh};
        e = {1'b0, x[30:23]};
        if (s[27]) begin
            sticky = sticky | s[0];
            s      = s >> 1;
            e      = e + 9'd1;
        end
        up = s[2] & (s[1] | s[0] | sticky | s[3]);
        m  = {1'b0, s[26:3]} + {24'd0, up};
        if (m[24]) begin
            m = m >> 1;
            e = e + 9'd1;
        end
        if (e >= 9'd255) return {1'b0, 8'hFF, 23'd0};
        return {1'b0, e[7:0], m[22:0]};
    endfunction

    // Float divide for non-negative operands; the caller guards a zero divisor.
    function automatic logic [31:0] fp_div(input logic [31:0] a, input logic [31:0] b);
        logic [49:0]        n, dv;
        logic [26:0]        q;
        logic               rem_nz, g, st, up;
        logic [23:0]        mant;
        logic [24:0]        m;
        logic signed [9:0]  e;
        if (a[30:23] == 8'd0) return 32'h0;
        if (b[30:23] == 8'd0) return {1'b0, 8'hFF, 23'd0};
        n      = {1'b1, a[22:0], 26'd0};
        dv     = {26'd0, 1'b1, b[22:0]};
        q      = 27'(n / dv);
        rem_nz = ((n % dv) != 50'd0);
        e      = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;
        if (q[26]) begin
            mant = q[26:3];
            g    = q[2];
            st   = q[1] | q[0] | rem_nz;
        end else begin
            mant = q[25:2];
            g    = q[1];
            st   = q[0] | rem_nz;
            e    = e - 10'sd1;
        end
        up = g & (st | mant[0]);
        m  = {1'b0, mant} + {24'd0, up};
        if (m[24]) begin
            m = m >> 1;
            e = e + 10'sd1;
        end
        if (e <= 10'sd0) return 32'h0;
        if (e >= 10'sd255) return {1'b0, 8'hFF, 23'd0};
        return {1'b0, e[7:0], m[22:0]};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = 32'h0;
        out_last   = 1'b0;
        in_end     = 1'b0;
        case (state)
            LOAD: begin
                in_ready = started;
                in_end   = in_last || (wr_idx == IDXW'(N - 1));
                if (in_valid && started && in_end) state_next = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = (rd_idx == len - IDXW'(1));
                if (acc[30:0] != 31'd0) out_data = fp_div(mem[rd_idx[AW-1:0]], acc);
                if (out_ready && out_last) state_next = LOAD;
            end
            default: state_next = LOAD;
        endcase
    end

    // started holds in_ready low until the first edge after reset releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx  <= '0;
            rd_idx  <= '0;
            len     <= '0;
            acc     <= 32'h0;
            started <= 1'b0;
        end else begin
            started <= 1'b1;
            if (state == LOAD && in_valid && in_ready) begin
                acc    <= fp_add(acc, in_data);
                wr_idx <= wr_idx + IDXW'(1);
                if (in_end) begin
                    len    <= wr_idx + IDXW'(1);
                    rd_idx <= '0;
                end
            end else if (state == DRAIN && out_ready) begin
                rd_idx <= rd_idx + IDXW'(1);
                if (out_last) begin
                    wr_idx <= '0;
                    rd_idx <= '0;
                    acc    <= 32'h0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == LOAD && in_valid && in_ready) mem[wr_idx[AW-1:0]] <= in_data;
    end

    assign busy = (state == DRAIN) || (wr_idx != '0);

endmodule

// File: tb/tb_softmax_normalizer.sv
// Directed self-checking bench for softmax_normalizer with hand-computed float results.
module tb_softmax_normalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last;
    logic        out_valid, out_ready, out_last, busy;
    logic [31:0] in_data, out_data;

    int          checks = 0;
    int          failures = 0;

    logic [31:0] cap_data [16];
    logic        cap_last [16];
    int          cap_n, cap_unstable;

    softmax_normalizer #(.N(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Drives one word for one cycle; called 1ns after a rising edge while in LOAD.
    task automatic send(input logic [31:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Records output handshakes and counts held words that changed under backpressure.
    task automatic collect(input int max_n, input int budget, input bit toggle);
        logic        held;
        logic [31:0] hd;
        logic        hl;
        cap_n = 0; cap_unstable = 0; held = 1'b0; hd = '0; hl = 1'b0;
        for (int c = 0; c < budget && cap_n < max_n; c++) begin
            out_ready = toggle ? c[0] : 1'b1;
            #1;
            if (held && out_valid && (out_data !== hd || out_last !== hl)) cap_unstable++;
            held = 1'b0;
            if (out_valid && out_ready) begin
                cap_data[cap_n] = out_data;
                cap_last[cap_n] = out_last;
                cap_n++;
            end else if (out_valid) begin
                held = 1'b1; hd = out_data; hl = out_last;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({in_ready, out_valid, out_last, busy} !== 4'b0000) begin failures++; $display("[TB] FAIL reset_ctrl got=%b exp=0000", {in_ready, out_valid, out_last, busy}); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_data got=%h exp=00000000", out_data); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL ready_before_edge got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL ready_after_edge got=%b exp=1", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_basic;
        logic [31:0] exp_d [3];
        exp_d = '{32'h3E800000, 32'h3F000000, 32'h3E800000};
        send(32'h3F800000, 1'b0);
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL basic_busy_load got=%b exp=1", busy); end
        send(32'h40000000, 1'b0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_early_valid got=%b exp=0", out_valid); end
        send(32'h3F800000, 1'b1);
        checks++; if ({out_valid, in_ready, busy} !== 3'b101) begin failures++; $display("[TB] FAIL basic_latency got=%b exp=101", {out_valid, in_ready, busy}); end
        collect(3, 20, 1'b0);
        checks++; if (cap_n != 3) begin failures++; $display("[TB] FAIL basic_count got=%0d exp=3", cap_n); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (cap_data[i] !== exp_d[i] || cap_last[i] !== (i == 2)) begin failures++; $display("[TB] FAIL basic_out%0d got=%h/%b exp=%h/%b", i, cap_data[i], cap_last[i], exp_d[i], (i == 2)); end
        end
        checks++; if ({out_valid, in_ready, busy} !== 3'b010) begin failures++; $display("[TB] FAIL basic_turnaround got=%b exp=010", {out_valid, in_ready, busy}); end
    endtask

    task automatic test_full_vector;
        for (int i = 0; i < 8; i++) send(32'h3F800000, 1'b0);
        checks++; if ({in_ready, out_valid} !== 2'b01) begin failures++; $display("[TB] FAIL full_drain_ready got=%b exp=01", {in_ready, out_valid}); end
        collect(8, 30, 1'b0);
        checks++; if (cap_n != 8) begin failures++; $display("[TB] FAIL full_count got=%0d exp=8", cap_n); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (cap_data[i] !== 32'h3E000000 || cap_last[i] !== (i == 7)) begin failures++; $display("[TB] FAIL full_out%0d got=%h/%b exp=3e000000/%b", i, cap_data[i], cap_last[i], (i == 7)); end
        end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL full_turnaround got=%b exp=1", in_ready); end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_d [3];
        exp_d = '{32'h3E800000, 32'h3F000000, 32'h3E800000};
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b0);
        send(32'h3F800000, 1'b1);
        collect(3, 40, 1'b1);
        checks++; if (cap_n != 3) begin failures++; $display("[TB] FAIL bp_count got=%0d exp=3", cap_n); end
        checks++; if (cap_unstable != 0) begin failures++; $display("[TB] FAIL bp_stable got=%0d exp=0", cap_unstable); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (cap_data[i] !== exp_d[i] || cap_last[i] !== (i == 2)) begin failures++; $display("[TB] FAIL bp_out%0d got=%h/%b exp=%h/%b", i, cap_data[i], cap_last[i], exp_d[i], (i == 2)); end
        end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_extra got=%b exp=0", out_valid); end
    endtask

    task automatic test_single_and_zero;
        send(32'h40400000, 1'b1);
        checks++; if (out_last !== 1'b1) begin failures++; $display("[TB] FAIL single_last got=%b exp=1", out_last); end
        collect(1, 10, 1'b0);
        checks++; if (cap_n != 1 || cap_data[0] !== 32'h3F800000) begin failures++; $display("[TB] FAIL single_out got=%0d/%h exp=1/3f800000", cap_n, cap_data[0]); end
        send(32'h0, 1'b0);
        send(32'h0, 1'b0);
        send(32'h0, 1'b1);
        collect(3, 20, 1'b0);
        checks++; if (cap_n != 3) begin failures++; $display("[TB] FAIL zero_count got=%0d exp=3", cap_n); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (cap_data[i] !== 32'h0 || cap_last[i] !== (i == 2)) begin failures++; $display("[TB] FAIL zero_out%0d got=%h/%b exp=00000000/%b", i, cap_data[i], cap_last[i], (i == 2)); end
        end
    endtask

    task automatic test_reset_mid_drain;
        for (int i = 0; i < 4; i++) send(32'h3F800000, (i == 3));
        collect(2, 10, 1'b0);
        checks++; if (cap_n != 2 || cap_data[0] !== 32'h3E800000 || cap_data[1] !== 32'h3E800000) begin failures++; $display("[TB] FAIL abort_pre got=%0d/%h/%h exp=2/3e800000/3e800000", cap_n, cap_data[0], cap_data[1]); end
        rst = 1'b1;
        #1;
        checks++; if ({out_valid, busy, in_ready} !== 3'b000 || out_data !== 32'h0) begin failures++; $display("[TB] FAIL abort_reset got=%b/%h exp=000/00000000", {out_valid, busy, in_ready}, out_data); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("[TB] FAIL abort_recover got=%b exp=10", {in_ready, out_valid}); end
        send(32'h40000000, 1'b0);
        send(32'h40000000, 1'b1);
        collect(2, 10, 1'b0);
        checks++; if (cap_n != 2) begin failures++; $display("[TB] FAIL abort_count got=%0d exp=2", cap_n); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (cap_data[i] !== 32'h3F000000 || cap_last[i] !== (i == 1)) begin failures++; $display("[TB] FAIL abort_out%0d got=%h/%b exp=3f000000/%b", i, cap_data[i], cap_last[i], (i == 1)); end
        end
    endtask

    task automatic test_junk_in_drain;
        logic [31:0] exp_d [3];
        exp_d = '{32'h3E800000, 32'h3F000000, 32'h3E800000};
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b0);
        send(32'h3F800000, 1'b1);
        in_valid = 1'b1; in_data = 32'h42C80000; in_last = 1'b1;
        collect(3, 20, 1'b0);
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (cap_n != 3) begin failures++; $display("[TB] FAIL junk_count got=%0d exp=3", cap_n); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (cap_data[i] !== exp_d[i]) begin failures++; $display("[TB] FAIL junk_out%0d got=%h exp=%h", i, cap_data[i], exp_d[i]); end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL junk_busy got=%b exp=0", busy); end
        send(32'h3F800000, 1'b0);
        send(32'h40400000, 1'b1);
        collect(2, 10, 1'b0);
        checks++; if (cap_n != 2 || cap_data[0] !== 32'h3E800000 || cap_data[1] !== 32'h3F400000 || cap_last[1] !== 1'b1) begin failures++; $display("[TB] FAIL junk_next got=%0d/%h/%h/%b exp=2/3e800000/3f400000/1", cap_n, cap_data[0], cap_data[1], cap_last[1]); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_full_vector();
        test_backpressure();
        test_single_and_zero();
        test_reset_mid_drain();
        test_junk_in_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
